// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared types and helpers for the parametrised FIR (param_fir_filter).
//   firState_e : controller states IDLE -> MAC -> SUM -> IDLE
//   accWidth   : per-bank accumulator width (product + growth over the taps)
//   sumWidth   : width of the cross-bank sum (accumulator + growth over banks)
//   saturate   : clamp a signed value to the signed range of outW bits
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SUM  = 2'd2
    } firState_e;

    function automatic int accWidth(int inW, int coefW, int taps);
        return inW + coefW + $clog2(taps);
    endfunction

    function automatic int sumWidth(int accW, int banks);
        return accW + $clog2(banks);
    endfunction

    // Works on a 64-bit carrier so one helper serves every parameter set;
    // the caller keeps only the low outW bits of the result.
    function automatic logic signed [63:0] saturate(logic signed [63:0] v, int outW);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (outW - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (outW - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/fir_bank_mac.sv
// -----------------------------------------------------------------------------
// fir_bank_mac
// One MAC bank: selects tap idx from its slice of the delay line and of the
// active coefficient set, multiplies them (signed) and accumulates.
// Ports:
//   iClk12M, iRsn : clock, async active-low reset
//   iSamples      : this bank's TAPS delay-line entries (entry 0 = lowest k)
//   iCoeffs       : this bank's TAPS active coefficients
//   iIdx          : tap index within the bank
//   iClr          : synchronous clear of the accumulator (start of sample)
//   iEn           : accumulate the current product
//   oAcc          : signed accumulator
// -----------------------------------------------------------------------------
module fir_bank_mac
    import fir_pkg::*;
#(
    parameter int TAPS   = 10,
    parameter int IN_W   = 3,
    parameter int COEF_W = 16,
    parameter int IDX_W  = $clog2(TAPS),
    parameter int ACC_W  = accWidth(IN_W, COEF_W, TAPS)
) (
    input  logic                           iClk12M,
    input  logic                           iRsn,
    input  logic [TAPS-1:0][IN_W-1:0]      iSamples,
    input  logic [TAPS-1:0][COEF_W-1:0]    iCoeffs,
    input  logic [IDX_W-1:0]               iIdx,
    input  logic                           iClr,
    input  logic                           iEn,
    output logic signed [ACC_W-1:0]        oAcc
);

    localparam int PROD_W = IN_W + COEF_W;

    logic signed [IN_W-1:0]   xSel;
    logic signed [COEF_W-1:0] hSel;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        xSel = signed'(iSamples[iIdx]);
        hSel = signed'(iCoeffs[iIdx]);
        // Both operands widened (sign-extended) to the full product width so
        // the multiply is exact.
        prod = PROD_W'(xSel) * PROD_W'(hSel);
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            oAcc <= '0;
        else if (iClr)
            oAcc <= '0;
        else if (iEn)
            oAcc <= oAcc + ACC_W'(prod);
    end

endmodule

// File: rtl/param_fir_filter.sv
// -----------------------------------------------------------------------------
// param_fir_filter
// NUM_BANK x TAPS_PER_BANK tap signed FIR, one output per accepted strobe.
// Banks MAC one tap per clock in parallel; a final cycle sums the banks.
// Coefficients are double-buffered (shadow written any time, copied to the
// active set on the first accepted strobe after a commit request).
// Build option: define FIR_SAT_EN to saturate the output to OUT_W bits;
// otherwise the output wraps (low OUT_W bits of the shifted sum).
// Ports:
//   iClk12M, iRsn      : clock, async active-low reset
//   iEnSample600k      : 1-cycle sample strobe, iFirIn valid with it
//   iFirIn             : signed input sample
//   iCoeffWr/Addr/Data : shadow coefficient write (addr >= N ignored)
//   iCoeffCommit       : request shadow -> active swap
//   oFirOut, oFirValid : registered output and its 1-cycle valid pulse
//   oBusy              : controller not IDLE
//   oCoeffPending      : commit requested, swap not yet applied
//   oOverrun           : sticky, strobe arrived while busy
// -----------------------------------------------------------------------------
module param_fir_filter
    import fir_pkg::*;
#(
    parameter int NUM_BANK      = 4,
    parameter int TAPS_PER_BANK = 10,
    parameter int IN_W          = 3,
    parameter int COEF_W        = 16,
    parameter int OUT_W         = 16,
    parameter int OUT_SHIFT     = 0
) (
    input  logic                                          iClk12M,
    input  logic                                          iRsn,
    input  logic                                          iEnSample600k,
    input  logic [IN_W-1:0]                               iFirIn,
    input  logic                                          iCoeffWr,
    input  logic [$clog2(NUM_BANK*TAPS_PER_BANK)-1:0]     iCoeffAddr,
    input  logic [COEF_W-1:0]                             iCoeffData,
    input  logic                                          iCoeffCommit,
    output logic [OUT_W-1:0]                              oFirOut,
    output logic                                          oFirValid,
    output logic                                          oBusy,
    output logic                                          oCoeffPending,
    output logic                                          oOverrun
);

    localparam int N     = NUM_BANK * TAPS_PER_BANK;
    localparam int AW    = $clog2(N);
    localparam int IW    = $clog2(TAPS_PER_BANK);
    localparam int ACC_W = accWidth(IN_W, COEF_W, TAPS_PER_BANK);
    localparam int SUM_W = sumWidth(ACC_W, NUM_BANK);

    localparam logic [AW:0]   TAP_LIMIT = (AW + 1)'(N);
    localparam logic [IW-1:0] IDX_LAST  = IW'(TAPS_PER_BANK - 1);

    firState_e state, nextState;

    logic [N-1:0][IN_W-1:0]       xLine;     // entry 0 is the newest sample
    logic [N-1:0][COEF_W-1:0]     shadow;
    logic [N-1:0][COEF_W-1:0]     active;
    logic [IW-1:0]                idx;
    logic [NUM_BANK-1:0][ACC_W-1:0] bankAcc;

    logic accept, accClr, accEn, outLoad, coeffWrOk;
    logic signed [SUM_W-1:0] bankSum;
    logic signed [SUM_W-1:0] shifted;
    logic [OUT_W-1:0]        outNext;

    assign accept    = iEnSample600k && (state == IDLE);
    assign coeffWrOk = iCoeffWr && ({1'b0, iCoeffAddr} < TAP_LIMIT);
    assign oBusy     = (state != IDLE);

    // ---------------- controller ----------------
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        accClr    = 1'b0;
        accEn     = 1'b0;
        outLoad   = 1'b0;
        unique case (state)
            IDLE: begin
                if (iEnSample600k) begin
                    accClr    = 1'b1;
                    nextState = MAC;
                end
            end
            MAC: begin
                accEn = 1'b1;
                if (idx == IDX_LAST)
                    nextState = SUM;
            end
            SUM: begin
                outLoad   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            idx <= '0;
        else if (accept)
            idx <= '0;
        else if (accEn)
            idx <= idx + IW'(1);
    end

    // ---------------- delay line ----------------
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            xLine <= '0;
        else if (accept)
            xLine <= {xLine[N-2:0], iFirIn};
    end

    // ---------------- coefficient double buffer ----------------
    // The swap reads shadow's pre-edge value, so a write landing on the same
    // edge as the swap stays in shadow only and waits for the next commit.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            shadow <= '0;
        else if (coeffWrOk)
            shadow[iCoeffAddr] <= iCoeffData;
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            active <= '0;
        else if (accept && oCoeffPending)
            active <= shadow;
    end

    // A swap clears pending even if a commit arrives on the same edge.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            oCoeffPending <= 1'b0;
        else if (accept && oCoeffPending)
            oCoeffPending <= 1'b0;
        else if (iCoeffCommit)
            oCoeffPending <= 1'b1;
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn)
            oOverrun <= 1'b0;
        else if (iEnSample600k && (state != IDLE))
            oOverrun <= 1'b1;
    end

    // ---------------- MAC banks ----------------
    for (genvar b = 0; b < NUM_BANK; b++) begin : gBank
        fir_bank_mac #(
            .TAPS   (TAPS_PER_BANK),
            .IN_W   (IN_W),
            .COEF_W (COEF_W),
            .IDX_W  (IW),
            .ACC_W  (ACC_W)
        ) uBank (
            .iClk12M  (iClk12M),
            .iRsn     (iRsn),
            .iSamples (xLine[b*TAPS_PER_BANK +: TAPS_PER_BANK]),
            .iCoeffs  (active[b*TAPS_PER_BANK +: TAPS_PER_BANK]),
            .iIdx     (idx),
            .iClr     (accClr),
            .iEn      (accEn),
            .oAcc     (bankAcc[b])
        );
    end

    // ---------------- final sum and output conversion ----------------
    always_comb begin
        bankSum = '0;
        for (int b = 0; b < NUM_BANK; b++)
            bankSum = bankSum + SUM_W'(signed'(bankAcc[b]));
        shifted = bankSum >>> OUT_SHIFT;
    end

`ifdef FIR_SAT_EN
    assign outNext = OUT_W'(saturate(64'(shifted), OUT_W));
`else
    assign outNext = OUT_W'(shifted);
`endif

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            oFirOut   <= '0;
            oFirValid <= 1'b0;
        end else begin
            oFirValid <= outLoad;
            if (outLoad)
                oFirOut <= outNext;
        end
    end

endmodule

// File: tb/tb_param_fir_filter.sv
// -----------------------------------------------------------------------------
// tb_param_fir_filter
// Directed bench for param_fir_filter with default parameters (40 taps).
// Table-driven impulse/step vectors plus hand sequences for double buffering,
// latency/overrun, saturation, reset mid-MAC and swap ordering.
// -----------------------------------------------------------------------------
module tb_param_fir_filter;

    logic        clk;
    logic        rsn;
    logic        en;
    logic [2:0]  firIn;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        commit;
    logic [15:0] out;
    logic        valid;
    logic        busy;
    logic        pending;
    logic        overrun;

    param_fir_filter dut (
        .iClk12M       (clk),
        .iRsn          (rsn),
        .iEnSample600k (en),
        .iFirIn        (firIn),
        .iCoeffWr      (wr),
        .iCoeffAddr    (addr),
        .iCoeffData    (data),
        .iCoeffCommit  (commit),
        .oFirOut       (out),
        .oFirValid     (valid),
        .oBusy         (busy),
        .oCoeffPending (pending),
        .oOverrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  x;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[81];
    int   nChecks = 0;
    int   nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp)
            nPass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic w, input logic [5:0] a, input logic [15:0] d, input logic c);
        @(negedge clk);
        wr = w; addr = a; data = d; commit = c;
    endtask

    task automatic idleIn();
        @(negedge clk);
        wr = 1'b0; commit = 1'b0;
    endtask

    // Starts right after strobe deassertion (cycle 1); valid expected at 12.
    task automatic waitValid(output logic [15:0] y);
        int lat;
        lat = -1;
        y   = '0;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (valid) begin
                lat = c;
                y   = out;
                break;
            end
        end
        check("latency", 32'(lat), 32'd12);
    endtask

    task automatic sample(input logic [2:0] x, output logic [15:0] y);
        @(negedge clk);
        en = 1'b1; firIn = x;
        @(negedge clk);
        en = 1'b0; firIn = '0;
        waitValid(y);
    endtask

    task automatic loadCoefs(input bit ramp, input logic [15:0] val, input bit doCommit);
        for (int k = 0; k < 40; k++)
            drive(1'b1, 6'(k), ramp ? 16'(k + 1) : val, 1'b0);
        if (doCommit)
            drive(1'b0, '0, '0, 1'b1);
        idleIn();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rsn = 1'b0;
        @(negedge clk);
        rsn = 1'b1;
    endtask

    logic [15:0] y;
    bit          sawValid;

    initial begin
        rsn = 1'b0; en = 1'b0; firIn = '0; wr = 1'b0; addr = '0; data = '0; commit = 1'b0;

        // Expected results: h[k]=k+1 impulse, then h=1 step response.
        for (int k = 0; k < 40; k++) begin
            vecs[k].x = (k == 0) ? 3'd1 : 3'd0;
            vecs[k].y = 16'(k + 1);
        end
        vecs[40].x = 3'd0;
        vecs[40].y = 16'd0;
        for (int k = 0; k < 40; k++) begin
            vecs[41 + k].x = 3'd1;
            vecs[41 + k].y = 16'(k + 1);
        end

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_flags", 32'({valid, busy, pending, overrun}), 32'd0);
        rsn = 1'b1;

        // ---- impulse ----
        loadCoefs(1'b1, '0, 1'b1);
        check("pending_after_commit", 32'(pending), 32'd1);
        for (int i = 0; i <= 40; i++) begin
            sample(vecs[i].x, y);
            check($sformatf("impulse%0d", i), 32'(y), 32'(vecs[i].y));
            if (i == 0)
                check("pending_after_swap", 32'(pending), 32'd0);
        end

        // ---- double buffer ----
        loadCoefs(1'b0, 16'd1, 1'b1);
        for (int i = 41; i <= 80; i++) begin
            sample(vecs[i].x, y);
            check($sformatf("step%0d", i - 41), 32'(y), 32'(vecs[i].y));
        end
        loadCoefs(1'b0, 16'd2, 1'b0);
        check("pending_no_commit", 32'(pending), 32'd0);
        sample(3'd1, y);
        check("shadow_not_used", 32'(y), 32'd40);
        drive(1'b0, '0, '0, 1'b1);
        idleIn();
        check("pending_set", 32'(pending), 32'd1);
        sample(3'd1, y);
        check("committed_out", 32'(y), 32'd80);
        check("pending_clear", 32'(pending), 32'd0);

        // ---- latency / overrun (line all ones, h=2) ----
        check("overrun_clear", 32'(overrun), 32'd0);
        @(negedge clk);
        en = 1'b1; firIn = 3'd0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            en    = (c == 5 || c == 12);
            firIn = (c == 5) ? 3'd3 : 3'd0;
            check($sformatf("valid_c%0d", c), 32'(valid), 32'(c == 12 || c == 24));
            if (c == 3)  check("busy_c3", 32'(busy), 32'd1);
            if (c == 6)  check("overrun_set", 32'(overrun), 32'd1);
            if (c == 12) check("ovr_out1", 32'(out), 32'd78);
            if (c == 24) check("ovr_out2", 32'(out), 32'd76);
        end
        en = 1'b0;

        // ---- saturation / wrap ----
        loadCoefs(1'b0, 16'h7FFF, 1'b1);
        for (int i = 0; i < 40; i++) sample(3'd3, y);
`ifdef FIR_SAT_EN
        check("sat_pos", 32'(y), 32'h7FFF);
`else
        check("wrap_pos", 32'(y), 32'hFF88);
`endif
        for (int i = 0; i < 40; i++) sample(3'b100, y);
`ifdef FIR_SAT_EN
        check("sat_neg", 32'(y), 32'h8000);
`else
        check("wrap_neg", 32'(y), 32'h00A0);
`endif

        // ---- reset mid-MAC ----
        @(negedge clk);
        en = 1'b1; firIn = 3'd1;
        sawValid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (valid) sawValid = 1'b1;
            if (c == 6) rsn = 1'b0;
            if (c == 7) begin
                check("midrst_out", 32'(out), 32'd0);
                check("midrst_flags", 32'({valid, busy, pending, overrun}), 32'd0);
            end
            if (c == 8) rsn = 1'b1;
        end
        check("midrst_no_valid", 32'(sawValid), 32'd0);
        sample(3'd1, y);
        check("post_rst_zero_coefs", 32'(y), 32'd0);

        // ---- edge cases: bad address, write+commit, swap ordering ----
        pulseReset();
        drive(1'b1, 6'd40, 16'h1234, 1'b0);
        drive(1'b1, 6'd0, 16'd5, 1'b0);
        drive(1'b0, '0, '0, 1'b1);
        idleIn();
        sample(3'd1, y);
        check("addr40_ignored", 32'(y), 32'd5);

        drive(1'b1, 6'd1, 16'd7, 1'b1);
        idleIn();
        check("wr_commit_pending", 32'(pending), 32'd1);
        sample(3'd2, y);
        check("wr_commit_included", 32'(y), 32'd17);

        drive(1'b1, 6'd0, 16'd9, 1'b1);
        idleIn();
        @(negedge clk);
        en = 1'b1; firIn = 3'd1; wr = 1'b1; addr = 6'd0; data = 16'd3; commit = 1'b1;
        @(negedge clk);
        en = 1'b0; firIn = '0; wr = 1'b0; commit = 1'b0;
        check("swap_clears_pending", 32'(pending), 32'd0);
        waitValid(y);
        check("swap_before_write", 32'(y), 32'd23);
        sample(3'd0, y);
        check("active_unchanged", 32'(y), 32'd7);
        drive(1'b0, '0, '0, 1'b1);
        idleIn();
        sample(3'd1, y);
        check("late_write_committed", 32'(y), 32'd3);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/param_fir_filter.md
Name: param_fir_filter

Overview:
Parametrised successor of the 4-bank reconfigurable FIR. It computes a NUM_BANK×TAPS_PER_BANK-tap signed FIR, one output per accepted sample strobe. Banks run in parallel and each MACs one tap per clock. Coefficients are double-buffered: writes go to a shadow bank and are committed atomically at a sample boundary. Sits between the sample-rate front end and downstream output logic in the 12 MHz domain.

Parameters:
NUM_BANK, 4, number of parallel MAC banks (≥1)
TAPS_PER_BANK, 10, taps handled per bank (≥2)
IN_W, 3, signed input sample width
COEF_W, 16, signed coefficient width
OUT_W, 16, signed output width
OUT_SHIFT, 0, arithmetic right shift applied to the final sum before output

Ports:
iClk12M  in  1  system clock
iRsn  in  1  reset, asynchronous, active-low
iEnSample600k  in  1  sample strobe, 1-cycle pulse
iFirIn  in  IN_W  signed sample, valid with strobe
iCoeffWr  in  1  shadow coefficient write enable
iCoeffAddr  in  clog2(NUM_BANK*TAPS_PER_BANK)  tap index k = bank*TAPS_PER_BANK + idx
iCoeffData  in  COEF_W  signed coefficient
iCoeffCommit  in  1  request shadow→active swap
oFirOut  out  OUT_W  signed filter output, registered
oFirValid  out  1  1-cycle pulse, oFirOut updated
oBusy  out  1  high while not IDLE
oCoeffPending  out  1  commit requested, not yet applied
oOverrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (async, iRsn=0): all outputs 0; delay line, shadow and active coefficients 0; pending and overrun flags cleared; FSM to IDLE. Reset mid-operation aborts the computation with no oFirValid.
- Function: y[n] = Σ_{k=0}^{N-1} h[k]·x[n-k], N = NUM_BANK*TAPS_PER_BANK; delay line tap 0 is the newest sample.
- FSM IDLE→MAC→SUM→IDLE.
- IDLE: strobe at cycle 0 → on that edge: shift iFirIn into tap 0; if pending, active←shadow and pending←0; clear bank accumulators; idx←0; go to MAC.
- MAC: cycles 1..TAPS_PER_BANK. Each edge: acc_b += x[b*T+idx]·h[b*T+idx] for every bank b; idx++. Leave to SUM after idx=T-1.
- SUM: cycle T+1. Edge adds the bank accumulators, applies the shift and output conversion, registers oFirOut, sets oFirValid, goes to IDLE. oFirValid is high for exactly cycle T+2 (cycle 12 by default).
- A strobe is accepted only in IDLE. Minimum strobe spacing is T+2 cycles.
- A strobe while busy is ignored: delay line unchanged, oOverrun←1, held until reset.
- Widths:
  - product IN_W+COEF_W
  - bank accumulator ACC_W = IN_W+COEF_W+clog2(TAPS_PER_BANK)
  - total SUM_W = ACC_W+clog2(NUM_BANK)
  - all arithmetic signed, no internal overflow
- Output: sum >>> OUT_SHIFT, then converted to OUT_W (see Optional Feature).
- Coefficient write: accepted every cycle in any state, into shadow only. Writes with iCoeffAddr ≥ N are ignored. The active set never changes mid-computation.
- Commit: sets pending on the edge; repeated commits are idempotent.
- Write and commit in the same cycle: the write is included in the swap.
- Write in the same cycle as an accepted strobe with pending set: the swap copies shadow before that write lands. The write stays in shadow and pending is cleared.

Optional Feature:
FIR_SAT_EN.
- Defined: shifted sum saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: low OUT_W bits are taken (two's-complement wrap).

Decomposition:
- Package fir_pkg: FSM state enum (IDLE, MAC, SUM), the ACC_W/SUM_W width functions, and the saturate function.
- Sub-module fir_bank_mac, instantiated NUM_BANK times: per-bank coefficient slice mux, multiplier and accumulator with clear/enable.

Test Plan:
- Impulse: load h[k]=k+1 for k=0..39, commit, then x=1 followed by zeros → outputs 1,2,…,40, then 0.
- Double buffer: stream x=1 with h=all 1 (out 40); write all h=2 without commit → still 40, oCoeffPending=0. Commit → pending=1; next sample gives 80 and pending=0.
- Latency/overrun: strobe at cycle 0 → oFirValid at cycle 12 only. A second strobe at cycle 5 → ignored, oOverrun=1. A strobe at cycle 12 → accepted.
- Saturation: h all 0x7FFF, x=3 steady → sum 3,932,040. With FIR_SAT_EN: 0x7FFF; without: 0xFF88. With x=-4 and FIR_SAT_EN: 0x8000.
- Reset mid-MAC: drop iRsn at cycle 6 → no oFirValid, all outputs 0. After release, impulse yields 0 until coefficients are reloaded and committed.
- Edge cases: write addr 40 (ignored), and write+commit+strobe in the same cycle → checked against the swap-ordering rules above.
